// File: rtl/alu_pkg.sv
// Shared ALU constants and the XOR inverse checker state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

    localparam int ALU_WIDTH   = 32;
    localparam int CHECK_CHUNK = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } chk_state_t;

endpackage

// File: rtl/lsb_priority_enc.sv
// Lowest-set-bit priority encoder: index of the least significant 1 plus a valid flag.
// Latency: combinational.
// Backpressure: none; index is 0 and valid is 0 for an all-zero mask.
module lsb_priority_enc #(
    parameter int WIDTH = 32,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] i_mask,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_vld
);

    // Scan from the MSB down so the lowest set bit is the last one to win.
    always_comb begin
        o_idx = '0;
        o_vld = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i_mask[i]) begin
                o_idx = IDX_W'(i);
                o_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/xor_inverse_checker.sv
// Recovers operand0 as result ^ operand1 CHUNK bits per cycle and reports the verdict.
// Latency: done pulses WIDTH/CHUNK+1 cycles after the accepting handshake.
// Backpressure: in_ready is low from accept until the cycle after done.
module xor_inverse_checker
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int CHUNK = CHECK_CHUNK,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         operand0,
    input  logic [WIDTH-1:0]         operand1,
    input  logic [WIDTH-1:0]         result,
    input  logic                     clr_count,
    output logic                     done,
    output logic                     pass,
    output logic [WIDTH-1:0]         mismatch_mask,
    output logic [$clog2(WIDTH)-1:0] first_bad,
    output logic [CNT_W-1:0]         err_count
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int K_W    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int IDX_W  = $clog2(WIDTH);

    localparam logic [K_W-1:0]   K_LAST  = K_W'(NCHUNK - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    chk_state_t         r_state;
    chk_state_t         w_next_state;

    logic [WIDTH-1:0]   r_op0;
    logic [WIDTH-1:0]   r_op1;
    logic [WIDTH-1:0]   r_res;
    logic [WIDTH-1:0]   r_mask;
    logic [K_W-1:0]     r_k;

    logic               r_pass;
    logic [WIDTH-1:0]   r_mask_out;
    logic [IDX_W-1:0]   r_first_bad;
    logic [CNT_W-1:0]   r_err_cnt;

    logic               w_accept;
    logic               w_last;
    logic [WIDTH-1:0]   w_diff;
    logic [WIDTH-1:0]   w_mask_next;
    logic [IDX_W-1:0]   w_bad_idx;
    logic               w_bad_vld;

    assign in_ready      = (r_state == IDLE);
    assign done          = (r_state == DONE);
    assign pass          = r_pass;
    assign mismatch_mask = r_mask_out;
    assign first_bad     = r_first_bad;
    assign err_count     = r_err_cnt;

    assign w_accept = in_valid & in_ready;
    assign w_last   = (r_state == CHECK) && (r_k == K_LAST);

    // Any bit where result ^ operand1 disagrees with operand0 is a fault.
    assign w_diff = r_res ^ r_op1 ^ r_op0;

    // Working mask with the current slice folded in; at the last slice this is the full verdict.
    always_comb begin
        w_mask_next = r_mask;
        w_mask_next[r_k * CHUNK +: CHUNK] = w_diff[r_k * CHUNK +: CHUNK];
    end

    lsb_priority_enc #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_first_bad_enc (
        .i_mask (w_mask_next),
        .o_idx  (w_bad_idx),
        .o_vld  (w_bad_vld)
    );

    // State register; reset aborts any check in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: one accept, NCHUNK slice cycles, one verdict cycle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_next_state = CHECK;
            CHECK:   if (w_last)   w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Latch the triple on accept and build the mismatch mask one slice per cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_op0  <= '0;
            r_op1  <= '0;
            r_res  <= '0;
            r_mask <= '0;
            r_k    <= '0;
        end else if (w_accept) begin
            r_op0  <= operand0;
            r_op1  <= operand1;
            r_res  <= result;
            r_mask <= '0;
            r_k    <= '0;
        end else if (r_state == CHECK) begin
            r_mask <= w_mask_next;
            r_k    <= r_k + K_W'(1);
        end
    end

    // Verdict registers load on the edge into DONE so they are valid alongside done.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pass      <= 1'b0;
            r_mask_out  <= '0;
            r_first_bad <= '0;
        end else if (w_last) begin
            r_pass      <= ~w_bad_vld;
            r_mask_out  <= w_mask_next;
            r_first_bad <= w_bad_idx;
        end
    end

    // Saturating failure counter; a clear outranks a same-cycle increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err_cnt <= '0;
        end else if (clr_count) begin
            r_err_cnt <= '0;
        end else if ((r_state == DONE) && !r_pass && (r_err_cnt != CNT_MAX)) begin
            r_err_cnt <= r_err_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/xor_inverse_checker.md
Name: xor_inverse_checker

Overview:
- Sequential inverse of the ALU bitwise-XOR path. It accepts a captured (operand0, operand1, result) triple and recovers operand0 as result ^ operand1, CHUNK bits per cycle.
- It compares the recovered value against the true operand0 and reports pass/fail, a per-bit mismatch mask, the lowest failing bit index, and a saturating error count.
- It sits beside the ALU as a built-in self-check of the logic-gate datapath and can be fed from the ALU output register.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CHUNK, 8, bits checked per cycle; WIDTH % CHUNK must be 0.
- CNT_W, 16, width of the saturating error counter.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  triple presented.
- in_ready  output  1  checker idle and able to accept.
- operand0  input  WIDTH  original operand 0.
- operand1  input  WIDTH  original operand 1.
- result  input  WIDTH  XOR result under test.
- clr_count  input  1  synchronous clear of err_count.
- done  output  1  one-cycle pulse when the verdict is valid.
- pass  output  1  1 = recovered equals operand0; held until the next done.
- mismatch_mask  output  WIDTH  1 per failing bit; held until the next done.
- first_bad  output  $clog2(WIDTH)  lowest failing bit index; 0 when pass.
- err_count  output  CNT_W  number of failed checks, saturating.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, in_ready=1, done=0, pass=0, mismatch_mask=0, first_bad=0, err_count=0.
  - Internal operand and chunk registers cleared.
  - Reset mid-CHECK aborts the check; no done pulse is produced.
- FSM states: IDLE, CHECK, DONE.
  - IDLE: in_ready=1. A handshake (in_valid & in_ready) latches all three inputs, clears the working mask, sets chunk index k=0, and moves to CHECK.
  - CHECK: in_ready=0. Each cycle computes working_mask[k*CHUNK +: CHUNK] = (result ^ operand1 ^ operand0) on that slice, then k++. After slice WIDTH/CHUNK-1 it moves to DONE.
  - DONE: for exactly one cycle it drives done=1 and updates pass = (mask==0), mismatch_mask, and first_bad (priority encode, lowest index). If the check failed, err_count increments. Returns to IDLE.
- Latency: the handshake is at cycle 0 and done is high at cycle WIDTH/CHUNK + 1. With defaults that is cycle 5; the next accept is possible at cycle 6.
- Inputs that change after the handshake are ignored; only the latched copies are used.
- in_valid while busy is not accepted. The producer holds in_valid until in_ready.
- err_count saturates at 2^CNT_W-1 and does not wrap.
- clr_count:
  - Clears err_count on the next edge in any state.
  - If clr_count coincides with a DONE increment, the clear wins (result 0).
- pass, mismatch_mask and first_bad change only in DONE. Between checks they hold the last verdict.
- CHUNK=WIDTH is legal: a single CHECK cycle, so done lands at cycle 2.
- Every bit 0..WIDTH-1, including the MSB, must be covered. A result with an undriven or wrong MSB must fail.

Decomposition:
- Shared package `alu_pkg` holds:
  - ALU_WIDTH=32 and CHECK_CHUNK=8 constants.
  - The checker state enum {IDLE, CHECK, DONE}.
- One natural sub-module: `lsb_priority_enc` (WIDTH mask → index of lowest set bit plus a valid flag), reusable by other ALU flag logic.
- Everything else stays in `xor_inverse_checker`.

Test Plan:
- Reset mid-CHECK: accept, assert reset_n=0 at cycle 2, release → no done, in_ready=1, all outputs 0.
- Correct XOR: operand0=0xDEADBEEF, operand1=0x12345678, result=0xCC99E897 → done at cycle 5, pass=1, mask=0, first_bad=0, err_count=0.
- MSB fault: operand0=0x80000000, operand1=0, result=0x00000000 → pass=0, mask=0x80000000, first_bad=31, err_count=1.
- Multi-bit fault: correct result with bits 3 and 17 flipped → mask=0x00020008, first_bad=3. Two back-to-back failures with in_valid held high → second accept at cycle 6, err_count=2.
- Busy and input stability: in_valid asserted during CHECK → in_ready=0, no accept. Inputs changed after the handshake → verdict uses the latched values.
- Counter saturation and clear:
  - Force CNT_W=4 and run 17 failing checks → err_count=15.
  - clr_count coinciding with a failing DONE → err_count=0.
